// File: rtl/count_seq_arbiter.sv
// rtl/count_seq_arbiter.sv - round-robin arbiter sequencing a shared up-counter (optional SEQ_PAUSE_EN)
// Two requesters each ask for a 0..len count run; the grant, count and done pulse are all registered.
module count_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
`ifdef SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             done0,
    output logic             done1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic             owner_q;
    logic             last_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;
    logic             done0_q;
    logic             done1_q;

    logic             winner_d;
    logic             freeze_d;

    // On a tie the requester that did not own the previous job wins.
    always_comb begin
        winner_d = (req0 && req1) ? ~last_q : req1;
`ifdef SEQ_PAUSE_EN
        freeze_d = pause;
`else
        freeze_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (req0 || req1) begin
                        state_q  <= RUN;
                        target_q <= winner_d ? len1 : len0;
                        owner_q  <= winner_d;
                        gnt0_q   <= ~winner_d;
                        gnt1_q   <= winner_d;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    // abort beats both pause and the terminal check
                    if (abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        last_q  <= owner_q;
                    end else if (!freeze_d) begin
                        if (count_q == target_q) begin
                            state_q <= DONE;
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                        end else begin
                            count_q <= count_q + ONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    last_q  <= owner_q;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done0 = done0_q;
    assign done1 = done1_q;

endmodule
